// File: rtl/alu_seq_if.sv
// alu_seq_if: operator encoding and issue/result bundle between the issue stage and alu_seq.
package ariane_pkg;
  typedef enum logic [5:0] {
    ANDL, ORL, XORL, ADD, SUB, SLL, SRL, SRA, SLTS, SLTU,
    EQ, NE, LTS, LTU, GES, GEU,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    CLZ, CTZ, CPOP, CLZW, CTZW, CPOPW,
    MIN, MAX, MINU, MAXU
  } fu_op;
endpackage

interface alu_seq_if #(parameter int XLEN = 64, parameter int TRANS_ID_BITS = 3);
  import ariane_pkg::*;
  logic flush_i;
  logic valid_i;
  logic ready_o;
  fu_op operator_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic valid_o;
  logic [XLEN-1:0] result_o;
  logic branch_res_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;
  modport master (
    output flush_i, valid_i, operator_i, operand_a_i, operand_b_i, trans_id_i,
    input  ready_o, valid_o, result_o, branch_res_o, trans_id_o
  );
  modport slave (
    input  flush_i, valid_i, operator_i, operand_a_i, operand_b_i, trans_id_i,
    output ready_o, valid_o, result_o, branch_res_o, trans_id_o
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU with registered result and an iterative CHUNK-per-cycle bit counter.
module alu_seq
  import ariane_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CHUNK = 8,
  parameter int TRANS_ID_BITS = 3
) (
  input logic clk_i,
  input logic rst_i,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int AW = $clog2(XLEN + 1);
  localparam int N = XLEN / CHUNK;
  localparam int NW = 32 / CHUNK;
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state_q, state_d;
  logic valid_q, valid_d, branch_q, branch_d, found_q, found_d, pop_q, pop_d;
  logic [XLEN-1:0] result_q, result_d, sh_q, sh_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic [AW-1:0] acc_q, acc_d, pc, lz;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, is_cnt, is_w, lts, ltu, alu_br;
  logic [XLEN-1:0] a, b, alu_res, rev_a;
  logic [31:0] aw, bw, rev_aw;
  logic [CHUNK-1:0] slice;
  fu_op op;
  function automatic logic [XLEN-1:0] sext(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction
  assign op = bus.operator_i;
  assign a = bus.operand_a_i;
  assign b = bus.operand_b_i;
  assign aw = a[31:0];
  assign bw = b[31:0];
  assign lts = $signed(a) < $signed(b);
  assign ltu = a < b;
  assign bus.ready_o = state_q == IDLE;
  assign accept = bus.valid_i & bus.ready_o & ~bus.flush_i;
  assign is_cnt = op inside {CLZ, CTZ, CPOP, CLZW, CTZW, CPOPW};
  assign is_w = op inside {CLZW, CTZW, CPOPW};
  assign slice = sh_q[XLEN-1 -: CHUNK];
  assign bus.valid_o = valid_q;
  assign bus.result_o = result_q;
  assign bus.branch_res_o = branch_q;
  assign bus.trans_id_o = tid_q;
  always_comb begin
    alu_res = '0;
    alu_br = 1'b1;
    case (op)
      ANDL: alu_res = a & b;
      ORL:  alu_res = a | b;
      XORL: alu_res = a ^ b;
      ADD:  alu_res = a + b;
      SUB:  alu_res = a - b;
      SLL:  alu_res = a << b[SW-1:0];
      SRL:  alu_res = a >> b[SW-1:0];
      SRA:  alu_res = $unsigned($signed(a) >>> b[SW-1:0]);
      SLTS: alu_res = XLEN'(lts);
      SLTU: alu_res = XLEN'(ltu);
      EQ:   alu_br = a == b;
      NE:   alu_br = a != b;
      LTS:  alu_br = lts;
      LTU:  alu_br = ltu;
      GES:  alu_br = ~lts;
      GEU:  alu_br = ~ltu;
      ADDW: alu_res = sext(aw + bw);
      SUBW: alu_res = sext(aw - bw);
      SLLW: alu_res = sext(aw << bw[4:0]);
      SRLW: alu_res = sext(aw >> bw[4:0]);
      SRAW: alu_res = sext($unsigned($signed(aw) >>> bw[4:0]));
      MIN:  alu_res = lts ? a : b;
      MAX:  alu_res = lts ? b : a;
      MINU: alu_res = ltu ? a : b;
      MAXU: alu_res = ltu ? b : a;
      default: alu_res = '0;
    endcase
  end
  // Bit-reversed operands let CTZ reuse the MSB-first leading-zero scan.
  always_comb begin
    rev_a = '0;
    rev_aw = '0;
    pc = '0;
    lz = AW'(CHUNK);
    for (int i = 0; i < XLEN; i++) rev_a[i] = a[XLEN-1-i];
    for (int i = 0; i < 32; i++) rev_aw[i] = aw[31-i];
    for (int i = 0; i < CHUNK; i++) begin
      pc = pc + AW'(slice[i]);
      if (slice[i]) lz = AW'(CHUNK - 1 - i);
    end
  end
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    result_d = result_q;
    branch_d = branch_q;
    tid_d = tid_q;
    sh_d = sh_q;
    acc_d = acc_q;
    found_d = found_q;
    cnt_d = cnt_q;
    pop_d = pop_q;
    if (state_q == COUNT) begin
      acc_d = acc_q + (pop_q ? pc : found_q ? '0 : lz);
      found_d = found_q | (|slice);
      sh_d = sh_q << CHUNK;
      cnt_d = cnt_q - CW'(1);
      if (bus.flush_i) state_d = IDLE;
      else if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        valid_d = 1'b1;
        result_d = XLEN'(acc_d);
        branch_d = 1'b1;
      end
    end else if (accept) begin
      tid_d = bus.trans_id_i;
      if (is_cnt) begin
        state_d = COUNT;
        pop_d = op inside {CPOP, CPOPW};
        acc_d = '0;
        found_d = 1'b0;
        cnt_d = is_w ? CW'(NW) : CW'(N);
        sh_d = op == CTZ ? rev_a : op == CTZW ? XLEN'(rev_aw) << (XLEN - 32) : is_w ? XLEN'(aw) << (XLEN - 32) : a;
      end else begin
        valid_d = 1'b1;
        result_d = alu_res;
        branch_d = alu_br;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      result_q <= '0;
      branch_q <= 1'b0;
      tid_q <= '0;
      sh_q <= '0;
      acc_q <= '0;
      found_q <= 1'b0;
      cnt_q <= '0;
      pop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      result_q <= result_d;
      branch_q <= branch_d;
      tid_q <= tid_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      found_q <= found_d;
      cnt_q <= cnt_d;
      pop_q <= pop_d;
    end
  end
endmodule
